// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - N-channel sprite compositor: shadowed Avalon registers, 3-stage VGA pixel pipeline
module sprite_compositor #(
    parameter int NUM_SPRITES = 8,
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int ROM_AW      = 10,
    parameter int HACTIVE     = 1280,
    parameter int VACTIVE     = 480
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic [8:0]                    address,
    input  logic [31:0]                   writedata,
    input  logic [10:0]                   hcount,
    input  logic [9:0]                    vcount,
    input  logic                          blank_n,
    output logic [NUM_SPRITES*ROM_AW-1:0] rom_addr,
    input  logic [NUM_SPRITES*16-1:0]     rom_data,
    output logic [7:0]                    VGA_R,
    output logic [7:0]                    VGA_G,
    output logic [7:0]                    VGA_B,
    output logic                          frame_commit
);
    localparam int CW = $clog2(SPRITE_W);

    logic [10:0] sh_x_q [NUM_SPRITES], sh_x_d [NUM_SPRITES], act_x_q [NUM_SPRITES];
    logic [9:0]  sh_y_q [NUM_SPRITES], sh_y_d [NUM_SPRITES], act_y_q [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] sh_en_q, sh_en_d, act_en_q, sh_fl_q, sh_fl_d, act_fl_q;
    logic [15:0] sh_bg_q, sh_bg_d, act_bg_q, sh_key_q, sh_key_d, act_key_q;
    logic        commit, commit_q;
    logic [15:0] unused_wdata_hi;

    assign unused_wdata_hi = writedata[31:16];
    assign commit          = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
    assign frame_commit    = commit_q;

    always_comb begin
        sh_x_d   = sh_x_q;
        sh_y_d   = sh_y_q;
        sh_en_d  = sh_en_q;
        sh_fl_d  = sh_fl_q;
        sh_bg_d  = sh_bg_q;
        sh_key_d = sh_key_q;
        if (chipselect && write) begin
            if (address == 9'h100) begin
                sh_bg_d = writedata[15:0];
            end else if (address == 9'h101) begin
                sh_key_d = writedata[15:0];
            end else if (!address[8]) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (address[7:2] == 6'(i)) begin
                        case (address[1:0])
                            2'd0:    sh_x_d[i] = writedata[10:0];
                            2'd1:    sh_y_d[i] = writedata[9:0];
                            2'd2:    begin
                                sh_en_d[i] = writedata[0];
                                sh_fl_d[i] = writedata[1];
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // The commit copies the next-state shadow, so a write in the commit cycle lands this frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x_q[i]  <= '0;
                sh_y_q[i]  <= '0;
                act_x_q[i] <= '0;
                act_y_q[i] <= '0;
            end
            sh_en_q   <= '0;
            sh_fl_q   <= '0;
            act_en_q  <= '0;
            act_fl_q  <= '0;
            sh_bg_q   <= 16'hFFFF;
            act_bg_q  <= 16'hFFFF;
            sh_key_q  <= 16'hF81F;
            act_key_q <= 16'hF81F;
            commit_q  <= 1'b0;
        end else begin
            sh_x_q   <= sh_x_d;
            sh_y_q   <= sh_y_d;
            sh_en_q  <= sh_en_d;
            sh_fl_q  <= sh_fl_d;
            sh_bg_q  <= sh_bg_d;
            sh_key_q <= sh_key_d;
            commit_q <= commit;
            if (commit) begin
                act_x_q   <= sh_x_d;
                act_y_q   <= sh_y_d;
                act_en_q  <= sh_en_d;
                act_fl_q  <= sh_fl_d;
                act_bg_q  <= sh_bg_d;
                act_key_q <= sh_key_d;
            end
        end
    end

    logic [NUM_SPRITES-1:0] hit_d, hit_s0_q, hit_s1_q;
    logic                   blank_s0_q, blank_s1_q;
    logic                   in_active;

    assign in_active = (hcount < 11'(HACTIVE)) && (vcount < 10'(VACTIVE));

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        logic [CW-1:0]     dx, col;
        logic [ROM_AW-1:0] addr_d, addr_q;
        logic              h_in, v_in;

        // Widened compares keep x+SPRITE_W from wrapping near the right edge.
        assign h_in = ({1'b0, hcount} >= {1'b0, act_x_q[g]}) &&
                      ({1'b0, hcount} <  ({1'b0, act_x_q[g]} + 12'(SPRITE_W)));
        assign v_in = ({1'b0, vcount} >= {1'b0, act_y_q[g]}) &&
                      ({1'b0, vcount} <  ({1'b0, act_y_q[g]} + 11'(SPRITE_H)));
        assign hit_d[g] = act_en_q[g] && h_in && v_in && in_active;
        assign dx       = CW'(hcount) - CW'(act_x_q[g]);
        assign col      = act_fl_q[g] ? ~dx : dx;
        assign addr_d   = ROM_AW'(ROM_AW'(vcount - act_y_q[g]) * ROM_AW'(SPRITE_W)) + ROM_AW'(col);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                addr_q <= '0;
            end else if (hit_d[g]) begin
                addr_q <= addr_d;
            end
        end

        assign rom_addr[g*ROM_AW +: ROM_AW] = addr_q;
    end

    logic [15:0] pix;
    logic [23:0] rgb_d, rgb_q;

    // Walk from highest index down so the lowest opaque index wins.
    always_comb begin
        pix = act_bg_q;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_s1_q[i] && (rom_data[i*16 +: 16] != act_key_q)) begin
                pix = rom_data[i*16 +: 16];
            end
        end
        rgb_d = '0;
        if (blank_s1_q) begin
            rgb_d = {pix[15:11], pix[15:13], pix[10:5], pix[10:9], pix[4:0], pix[4:2]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_s0_q   <= '0;
            hit_s1_q   <= '0;
            blank_s0_q <= 1'b0;
            blank_s1_q <= 1'b0;
            rgb_q      <= '0;
        end else begin
            hit_s0_q   <= hit_d;
            blank_s0_q <= blank_n;
            hit_s1_q   <= hit_s0_q;
            blank_s1_q <= blank_s0_q;
            rgb_q      <= rgb_d;
        end
    end

    assign VGA_R = rgb_q[23:16];
    assign VGA_G = rgb_q[15:8];
    assign VGA_B = rgb_q[7:0];
endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed self-checking bench for sprite_compositor
module tb_sprite_compositor;
    localparam int NS = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          chipselect, write;
    logic [8:0]    address;
    logic [31:0]   writedata;
    logic [10:0]   hcount;
    logic [9:0]    vcount;
    logic          blank_n;
    logic [NS*AW-1:0] rom_addr;
    logic [NS*16-1:0] rom_data;
    logic [7:0]    VGA_R, VGA_G, VGA_B;
    logic          frame_commit;
    logic [15:0]   rom_const [NS];
    int            tests = 0;
    int            fails = 0;

    sprite_compositor #(
        .NUM_SPRITES(NS), .SPRITE_W(32), .SPRITE_H(32), .ROM_AW(AW),
        .HACTIVE(1280), .VACTIVE(480)
    ) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .hcount(hcount), .vcount(vcount),
        .blank_n(blank_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .frame_commit(frame_commit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= {rom_const[3], rom_const[2], rom_const[1], rom_const[0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic pix(input string name, input int h, input int v, input logic [23:0] exp);
        hcount  = 11'(h);
        vcount  = 10'(v);
        blank_n = 1'b1;
        repeat (3) tick();
        chk(name, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp});
    endtask

    task automatic do_commit(input string name);
        hcount  = 11'd0;
        vcount  = 10'd480;
        blank_n = 1'b0;
        tick();
        hcount = 11'd1;
        chk({name, "_pulse"}, 32'(frame_commit), 32'd1);
        tick();
        chk({name, "_clear"}, 32'(frame_commit), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        hcount     = 11'd10;
        vcount     = 10'd10;
        blank_n    = 1'b1;
        rom_const[0] = 16'h07E0;
        rom_const[1] = 16'h001F;
        rom_const[2] = 16'hF800;
        rom_const[3] = 16'h001F;
        repeat (3) tick();
        chk("reset_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("reset_commit", 32'(frame_commit), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr[31:0]), 32'd0);

        reset_n = 1'b1;
        tick();
        tick();
        chk("latency_cycle2", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        tick();
        chk("latency_cycle3_bg", {8'h0, VGA_R, VGA_G, VGA_B}, 32'hFFFFFF);

        wr(9'd0, 32'd100);
        wr(9'd1, 32'd100);
        wr(9'd2, 32'd1);
        pix("s0_before_commit", 105, 105, 24'hFFFFFF);
        do_commit("c1");
        pix("s0_topleft", 100, 100, 24'h00FF00);
        pix("s0_botright", 131, 131, 24'h00FF00);
        pix("s0_right_out", 132, 100, 24'hFFFFFF);
        pix("s0_below_out", 100, 132, 24'hFFFFFF);
        pix("s0_left_out", 99, 100, 24'hFFFFFF);
        hcount = 11'd101;
        vcount = 10'd102;
        tick();
        chk("rom_addr0_101_102", 32'(rom_addr[9:0]), 32'd65);

        wr(9'd12, 32'd100);
        wr(9'd13, 32'd100);
        wr(9'd14, 32'd1);
        do_commit("c2");
        rom_const[0] = 16'hF81F;
        pix("prio_key_through", 110, 110, 24'h0000FF);
        rom_const[0] = 16'hF800;
        pix("prio_s0_on_top", 110, 110, 24'hFF0000);
        rom_const[0] = 16'h07E0;

        wr(9'd4, 32'd300);
        wr(9'd5, 32'd40);
        wr(9'd6, 32'd1);
        do_commit("c3");
        pix("s1_at_300", 310, 50, 24'h0000FF);
        hcount = 11'd0;
        vcount = 10'd50;
        wr(9'd4, 32'd200);
        pix("midframe_new_x_hidden", 210, 50, 24'hFFFFFF);
        pix("midframe_old_x_kept", 310, 50, 24'h0000FF);
        do_commit("c4");
        pix("next_frame_new_x", 210, 50, 24'h0000FF);
        pix("next_frame_old_x_gone", 310, 50, 24'hFFFFFF);

        hcount     = 11'd0;
        vcount     = 10'd480;
        blank_n    = 1'b0;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 9'd4;
        writedata  = 32'd1270;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        hcount     = 11'd1;
        chk("commit_cycle_write_pulse", 32'(frame_commit), 32'd1);
        pix("edge_1270", 1270, 50, 24'h0000FF);
        pix("edge_1279", 1279, 50, 24'h0000FF);
        pix("edge_1269", 1269, 50, 24'hFFFFFF);
        pix("edge_no_wrap_5", 5, 50, 24'hFFFFFF);

        wr(9'd8, 32'd0);
        wr(9'd9, 32'd0);
        wr(9'd10, 32'd3);
        do_commit("c5");
        hcount  = 11'd0;
        vcount  = 10'd0;
        blank_n = 1'b1;
        tick();
        chk("hflip_addr_0_0", 32'(rom_addr[29:20]), 32'd31);
        hcount = 11'd31;
        tick();
        chk("hflip_addr_31_0", 32'(rom_addr[29:20]), 32'd0);

        wr(9'd16, 32'd500);
        wr(9'd18, 32'd0);
        wr(9'h102, 32'd0);
        do_commit("c6");
        pix("unmapped_ignored_s0", 105, 105, 24'h00FF00);
        pix("unmapped_ignored_x0", 500, 100, 24'hFFFFFF);

        wr(9'h100, 32'h8410);
        pix("bg_shadow_only", 600, 200, 24'hFFFFFF);
        do_commit("c7");
        pix("bg_committed", 600, 200, 24'h848284);

        wr(9'h101, 32'h07E0);
        do_commit("c8");
        pix("key_reprogrammed", 105, 105, 24'h0000FF);

        hcount  = 11'd600;
        vcount  = 10'd200;
        blank_n = 1'b0;
        repeat (3) tick();
        chk("blank_black", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised N-channel sprite compositor for the VGA path of the Dino Run display. It sits between `vga_counters` and the VGA DAC pins. It takes per-sprite position and control over Avalon-MM, drives one address bus per external sprite ROM and composites RGB565 ROM data into 24-bit colour. Features:
- Fixed sprite-priority layering and a colour-key transparency.
- Horizontal flip per sprite.
- Frame-synchronous (tear-free) register updates.
- A background colour shown wherever no opaque sprite pixel lands.

## Interface
Parameters:
- NUM_SPRITES, 8, number of sprite channels (1..32)
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels
- ROM_AW, 10, ROM address width; must satisfy 2^ROM_AW >= SPRITE_W*SPRITE_H
- HACTIVE, 1280, active hcount range
- VACTIVE, 480, active lines

Ports:
- clk  in  1  system clock (50 MHz); one clock domain
- reset_n  in  1  asynchronous, active-low reset
- chipselect  in  1  Avalon-MM select
- write  in  1  Avalon-MM write strobe
- address  in  9  Avalon-MM word address
- writedata  in  32  Avalon-MM write data
- hcount  in  11  from vga_counters
- vcount  in  10  from vga_counters
- blank_n  in  1  from vga_counters; high in active region
- rom_addr  out  NUM_SPRITES*ROM_AW  per-sprite ROM address; sprite i occupies slice i
- rom_data  in  NUM_SPRITES*16  per-sprite RGB565 ROM data; 1-cycle registered ROM latency
- VGA_R, VGA_G, VGA_B  out  8 each  composited colour
- frame_commit  out  1  one-cycle pulse when shadow registers are copied to active

## Operation
Register map (word address). Writes go to shadow registers only:
- Sprite i, address 4i+0: x[10:0]
- Sprite i, address 4i+1: y[9:0]
- Sprite i, address 4i+2: bit0 enable, bit1 hflip
- Sprite i, address 4i+3: reserved
- 0x100: bg colour [15:0] RGB565
- 0x101: key colour [15:0] RGB565
- Writes to unmapped addresses, or to sprite index >= NUM_SPRITES, are ignored.

Reset values:
- All shadow and active sprite registers: x=0, y=0, enable=0, hflip=0.
- bg=16'hFFFF, key=16'hF81F.
- Outputs: VGA_R/G/B=0, rom_addr=0, frame_commit=0.

Frame commit:
- A commit occurs on the cycle where hcount==0 && vcount==VACTIVE (start of vertical blank).
- That cycle: active <= shadow for all registers, and frame_commit=1 on the next cycle.
- If an Avalon write lands in the commit cycle, the newly written value is committed (write forwards into the commit).

Hit test (stage 0, registered), per sprite i:
- Hit when enable && hcount>=x && hcount<x+SPRITE_W && vcount>=y && vcount<y+SPRITE_H.
- Compute in 12-bit (h) / 11-bit (v) so x+SPRITE_W never wraps. Sprites partly beyond HACTIVE/VACTIVE are clipped naturally.
- col = hflip ? SPRITE_W-1-(hcount-x) : (hcount-x).
- rom_addr_i = (vcount-y)*SPRITE_W + col, truncated to ROM_AW.
- On a miss, rom_addr_i holds its previous value; the hit flag is what matters.
- Stage 0 also registers blank_n and the hit vector.

Stage 1: rom_data valid for the stage-0 addresses; the hit vector and blank_n are delayed to align with it.

Stage 2 (output register):
- Select the lowest index i with hit_i && rom_data_i != key. Lower index has higher priority (drawn on top).
- If no sprite qualifies, use bg.
- If the delayed blank_n=0, output 0.
- RGB565 to 8-bit by MSB replication: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.

## Timing
- Pipeline latency: 3 clk cycles from hcount/vcount/blank_n input to VGA_R/G/B output. Integration delays VGA_HS/VS/BLANK_n by 3 to match.
- A pixel repeats on 2 consecutive clk cycles (VGA_CLK = hcount[0]), so no output bubble is tolerated; throughput is 1 pixel/cycle.
- An Avalon write takes effect in the shadow at the next edge. It becomes visible on screen only after the next frame_commit.
- Reset asserted mid-frame: all state clears asynchronously. After deassertion, output is bg in active regions (or 0 in blanking) from the 3rd cycle onward.

## Test plan
- Reset -> VGA_R/G/B=0 and frame_commit=0. With no writes, the first active pixel after 3 cycles outputs FF/FF/FF (bg 16'hFFFF).
- Sprite 0 at x=100,y=100, enabled, ROM all 16'h07E0; commit -> pixels (100..131,100..131) output 00/FF/00, and (132,100) outputs bg. rom_addr_0 at (101,102) = 65.
- Sprites 0 and 3 overlap; sprite 0 pixel = key 16'hF81F, sprite 3 = 16'h001F -> output 00/00/FF. With sprite 0 pixel 16'hF800 -> output FF/00/00.
- Write sprite 1 x=200 mid-frame (vcount=50) -> display unchanged until vcount==480,hcount==0. frame_commit pulses once, and the new x applies in the next frame. A write in the commit cycle itself is also applied.
- hflip=1, sprite at x=0,y=0 -> at (0,0) rom_addr=31, at (31,0) rom_addr=0.
- Sprite x=1270 -> pixels at hcount 1270..1279 drawn, no wrap into hcount 0..21. Write to address 4*NUM_SPRITES -> no register changes.
